// File: rtl/score_pkg.sv
// Shared widths, limits and FSM encoding for the score keeper slice.
package score_pkg;

    localparam int unsigned SCORE_W   = 14;
    localparam int unsigned PTS_W     = 8;
    localparam int unsigned MAX_SCORE = 9999;
    localparam int unsigned COMBO_W   = 2;
    // Base points shifted by the largest multiplier (x8) need three extra bits.
    localparam int unsigned PTS_SH_W  = PTS_W + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_CMP
    } state_t;

endpackage

// File: rtl/blink_timer.sv
// Celebration blinker: toggles the display enable every BLINK_HALF cycles
// for BLINK_TOGGLES toggles, then parks the enable high and goes idle.
module blink_timer #(
    parameter int unsigned BLINK_HALF    = 12_500_000,
    parameter int unsigned BLINK_TOGGLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    output logic enable
);

    localparam int unsigned TGL_W = $clog2(BLINK_TOGGLES + 1);

    logic             active_q, active_d;
    logic [23:0]      cnt_q, cnt_d;
    logic [TGL_W-1:0] tgl_q, tgl_d;
    logic             en_q, en_d;

    // Next-state: stop beats start; count half-periods while active.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        tgl_d    = tgl_q;
        en_d     = en_q;
        if (stop) begin
            active_d = 1'b0;
            cnt_d    = '0;
            tgl_d    = '0;
            en_d     = 1'b1;
        end else if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            tgl_d    = '0;
            en_d     = 1'b1;
        end else if (active_q) begin
            if (cnt_q == 24'(BLINK_HALF - 1)) begin
                cnt_d = '0;
                en_d  = ~en_q;
                tgl_d = tgl_q + TGL_W'(1);
                if (tgl_q == TGL_W'(BLINK_TOGGLES - 1)) begin
                    active_d = 1'b0;
                    en_d     = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 24'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            tgl_q    <= '0;
            en_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            tgl_q    <= tgl_d;
            en_q     <= en_d;
        end
    end

    assign enable = en_q;

endmodule

// File: rtl/score_keeper.sv
// Score accumulator with combo multiplier, saturation, session high score
// and a blinking celebration on the first new high of each game.
module score_keeper #(
    parameter int unsigned MAX_SCORE     = 9999,
    parameter int unsigned MAX_COMBO     = 3,
    parameter int unsigned BLINK_HALF    = 12_500_000,
    parameter int unsigned BLINK_TOGGLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         game_rst,
    input  logic                         hit_valid,
    output logic                         hit_ready,
    input  logic [score_pkg::PTS_W-1:0]  hit_points,
    input  logic                         combo_break,
    output logic [score_pkg::SCORE_W-1:0] score,
    output logic [score_pkg::SCORE_W-1:0] high_score,
    output logic                         new_high,
    output logic                         display_enable
);

    import score_pkg::*;

    localparam logic [SCORE_W:0]   MAX_S = (SCORE_W + 1)'(MAX_SCORE);
    localparam logic [COMBO_W-1:0] MAX_C = COMBO_W'(MAX_COMBO);

    state_t              state_q, state_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W-1:0]  high_q, high_d;
    logic                new_high_q, new_high_d;
    logic [COMBO_W-1:0]  combo_q, combo_d;
    logic [PTS_SH_W-1:0] pts_q, pts_d;

    logic [COMBO_W-1:0]  combo_eff;
    logic [SCORE_W:0]    sum;
    logic                blink_start;
    logic                blink_stop;

    // Next-state: game_rst overrides everything; otherwise run IDLE->ADD->CMP.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        high_d      = high_q;
        new_high_d  = new_high_q;
        combo_d     = combo_q;
        pts_d       = pts_q;
        sum         = '0;
        blink_start = 1'b0;
        blink_stop  = 1'b0;
        // A break in the handshake cycle is applied before the hit's multiplier.
        combo_eff   = combo_break ? '0 : combo_q;
        if (game_rst) begin
            state_d    = S_IDLE;
            score_d    = '0;
            combo_d    = '0;
            new_high_d = 1'b0;
            blink_stop = 1'b1;
        end else begin
            combo_d = combo_eff;
            case (state_q)
                S_IDLE: begin
                    if (hit_valid) begin
                        pts_d   = {{(PTS_SH_W - PTS_W){1'b0}}, hit_points} << combo_eff;
                        combo_d = (combo_eff < MAX_C) ? combo_eff + COMBO_W'(1) : MAX_C;
                        state_d = S_ADD;
                    end
                end
                S_ADD: begin
                    sum     = {1'b0, score_q} + {{(SCORE_W + 1 - PTS_SH_W){1'b0}}, pts_q};
                    score_d = (sum > MAX_S) ? MAX_S[SCORE_W-1:0] : sum[SCORE_W-1:0];
                    state_d = S_CMP;
                end
                S_CMP: begin
                    if (score_q > high_q) begin
                        high_d = score_q;
                        if (!new_high_q) begin
                            new_high_d  = 1'b1;
                            blink_start = 1'b1;
                        end
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            combo_q    <= '0;
            pts_q      <= '0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            combo_q    <= combo_d;
            pts_q      <= pts_d;
        end
    end

    blink_timer #(
        .BLINK_HALF    (BLINK_HALF),
        .BLINK_TOGGLES (BLINK_TOGGLES)
    ) u_blink (
        .clk    (clk),
        .reset  (reset),
        .start  (blink_start),
        .stop   (blink_stop),
        .enable (display_enable)
    );

    assign hit_ready  = (state_q == S_IDLE) && !game_rst;
    assign score      = score_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed table, hand sequences and random stimulus,
// all checked against a cycle-level behavioural model of the game rules.
module tb_score_keeper;

    localparam int HALF = 4;
    localparam int TOGS = 8;
    localparam int MAXS = 9999;

    logic       clk = 1'b0;
    logic       reset;
    logic       game_rst;
    logic       hit_valid;
    logic       hit_ready;
    logic [7:0] hit_points;
    logic       combo_break;
    logic [13:0] score;
    logic [13:0] high_score;
    logic       new_high;
    logic       display_enable;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    score_keeper #(
        .MAX_SCORE     (MAXS),
        .MAX_COMBO     (3),
        .BLINK_HALF    (HALF),
        .BLINK_TOGGLES (TOGS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .game_rst       (game_rst),
        .hit_valid      (hit_valid),
        .hit_ready      (hit_ready),
        .hit_points     (hit_points),
        .combo_break    (combo_break),
        .score          (score),
        .high_score     (high_score),
        .new_high       (new_high),
        .display_enable (display_enable)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A hit occupies three cycles: accept, score update, high-score compare.
    int m_score, m_high, m_nh, m_combo, m_busy, m_pts;
    int m_celeb, m_cstart, m_cyc, m_de;

    always @(posedge clk or negedge reset) begin
        int k;
        bit was_ready;
        if (!reset) begin
            m_score = 0; m_high = 0; m_nh = 0; m_combo = 0; m_busy = 0;
            m_pts = 0; m_celeb = 0; m_cstart = 0; m_cyc = 0; m_de = 1;
        end else begin
            m_cyc++;
            was_ready = (m_busy == 0) && !game_rst;
            if (game_rst) begin
                m_score = 0; m_combo = 0; m_nh = 0; m_busy = 0; m_celeb = 0;
            end else begin
                if (m_busy == 2) begin
                    m_score = (m_score + m_pts > MAXS) ? MAXS : m_score + m_pts;
                    m_busy  = 1;
                end else if (m_busy == 1) begin
                    if (m_score > m_high) begin
                        m_high = m_score;
                        if (m_nh == 0) begin
                            m_nh = 1; m_celeb = 1; m_cstart = m_cyc;
                        end
                    end
                    m_busy = 0;
                end
                if (combo_break) m_combo = 0;
                if (was_ready && hit_valid) begin
                    m_pts   = int'(hit_points) * (1 << m_combo);
                    m_combo = (m_combo < 3) ? m_combo + 1 : 3;
                    m_busy  = 2;
                end
            end
            if (m_celeb != 0) begin
                k = m_cyc - m_cstart;
                if (k >= HALF * TOGS) begin
                    m_celeb = 0; m_de = 1;
                end else begin
                    m_de = ((k / HALF) % 2 == 0) ? 1 : 0;
                end
            end else begin
                m_de = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #2;
        if (chk_on) begin
            chk("score",          int'(score),          m_score);
            chk("high_score",     int'(high_score),     m_high);
            chk("new_high",       int'(new_high),       m_nh);
            chk("display_enable", int'(display_enable), m_de);
            chk("hit_ready",      int'(hit_ready),      (m_busy == 0 && !game_rst) ? 1 : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!hit_ready && n < 20) begin
            tick();
            n++;
        end
        if (!hit_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got=0 want=1 at t=%0t", $time);
        end
    endtask

    task automatic do_hit(input logic [7:0] pts, input logic brk);
        wait_ready();
        hit_valid   = 1'b1;
        hit_points  = pts;
        combo_break = brk;
        tick();
        hit_valid   = 1'b0;
        combo_break = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_grst();
        game_rst = 1'b1;
        tick();
        game_rst = 1'b0;
    endtask

    task automatic count_toggles(input int cycles, output int toggles, output logic last);
        logic prev;
        toggles = 0;
        prev = display_enable;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (display_enable != prev) toggles++;
            prev = display_enable;
        end
        last = display_enable;
    endtask

    typedef struct {
        logic        grst;
        logic [7:0]  pts;
        logic        brk;
        int          exp_score;
        int          exp_high;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int tg;
        logic last;
        int sel;

        tbl[0]  = '{1'b1,   8'd5, 1'b0,    5,   20};
        tbl[1]  = '{1'b0,   8'd5, 1'b0,   15,   20};
        tbl[2]  = '{1'b0,   8'd5, 1'b0,   35,   35};
        tbl[3]  = '{1'b0,   8'd5, 1'b0,   75,   75};
        tbl[4]  = '{1'b0,   8'd5, 1'b0,  115,  115};
        tbl[5]  = '{1'b0,   8'd7, 1'b1,  122,  122};
        tbl[6]  = '{1'b0,   8'd7, 1'b0,  136,  136};
        tbl[7]  = '{1'b1,   8'd6, 1'b0,    6,  136};
        tbl[8]  = '{1'b0,   8'd0, 1'b0,    6,  136};
        tbl[9]  = '{1'b0,   8'd0, 1'b0,    6,  136};
        tbl[10] = '{1'b0, 8'd255, 1'b0, 2046, 2046};
        tbl[11] = '{1'b0, 8'd255, 1'b0, 4086, 4086};
        tbl[12] = '{1'b0, 8'd255, 1'b0, 6126, 6126};
        tbl[13] = '{1'b0, 8'd255, 1'b0, 8166, 8166};
        tbl[14] = '{1'b0, 8'd228, 1'b0, 9990, 9990};
        tbl[15] = '{1'b0, 8'd200, 1'b0, 9999, 9999};
        tbl[16] = '{1'b0,   8'd1, 1'b0, 9999, 9999};

        reset = 1'b0; game_rst = 1'b0; hit_valid = 1'b0;
        hit_points = '0; combo_break = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_on = 1'b1;
        tick();
        chk("rst_score", int'(score), 0);
        chk("rst_high", int'(high_score), 0);
        chk("rst_new_high", int'(new_high), 0);
        chk("rst_disp_en", int'(display_enable), 1);
        chk("rst_ready", int'(hit_ready), 1);

        // First hit of 10: score at N+1, high at N+2, ready low two cycles.
        hit_valid = 1'b1; hit_points = 8'd10;
        tick();
        hit_valid = 1'b0;
        chk("h1_ready_n", int'(hit_ready), 0);
        chk("h1_score_n", int'(score), 0);
        tick();
        chk("h1_score_n1", int'(score), 10);
        chk("h1_high_n1", int'(high_score), 0);
        chk("h1_ready_n1", int'(hit_ready), 0);
        tick();
        chk("h1_high_n2", int'(high_score), 10);
        chk("h1_new_high", int'(new_high), 1);
        chk("h1_ready_n2", int'(hit_ready), 1);

        // Celebration: eight toggles, ends high.
        count_toggles(40, tg, last);
        chk("blink_toggles", tg, TOGS);
        chk("blink_final", int'(last), 1);

        // Higher score in the same game does not restart the blink.
        do_hit(8'd5, 1'b0);
        chk("h2_score", int'(score), 20);
        chk("h2_high", int'(high_score), 20);
        count_toggles(40, tg, last);
        chk("no_restart_toggles", tg, 0);
        chk("no_restart_final", int'(last), 1);

        // Directed table: combo ramp, break, zero points, saturation.
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].grst) pulse_grst();
            do_hit(tbl[i].pts, tbl[i].brk);
            chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].exp_score);
            chk($sformatf("tbl%0d_high", i), int'(high_score), tbl[i].exp_high);
        end

        // game_rst during ADD drops the request and ignores a same-cycle handshake.
        wait_ready();
        hit_valid = 1'b1; hit_points = 8'd100;
        tick();
        game_rst = 1'b1;
        #1 chk("grst_ready_comb", int'(hit_ready), 0);
        tick();
        chk("grst_score", int'(score), 0);
        chk("grst_high_kept", int'(high_score), 9999);
        game_rst = 1'b0; hit_valid = 1'b0;
        #1;
        chk("grst_ready", int'(hit_ready), 1);
        chk("grst_disp_en", int'(display_enable), 1);
        chk("grst_new_high", int'(new_high), 0);
        tick(); tick(); tick();
        chk("grst_dropped", int'(score), 0);

        // Asynchronous reset mid-transaction.
        do_hit(8'd50, 1'b0);
        chk("pre_arst_score", int'(score), 50);
        hit_valid = 1'b1; hit_points = 8'd50;
        tick();
        hit_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_score", int'(score), 0);
        chk("arst_high", int'(high_score), 0);
        chk("arst_ready", int'(hit_ready), 1);
        chk("arst_disp_en", int'(display_enable), 1);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            hit_valid = ($urandom_range(0, 1) == 1);
            sel = int'($urandom_range(0, 3));
            hit_points = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(0, 255));
            combo_break = ($urandom_range(0, 9) == 0);
            game_rst = ($urandom_range(0, 59) == 0);
            tick();
        end
        hit_valid = 1'b0; combo_break = 1'b0; game_rst = 1'b0;
        repeat (5) tick();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
